// File: rtl/key_entry_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_entry_ctrl_pkg : shared array-key types, widths and controller states.
// Revision: 1.0
// ---------------------------------------------------------------------------
package key_entry_ctrl_pkg;

  localparam int KEY_W = 4;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] nibble_t;
  typedef logic [1:0]       state_t;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_CONV = 2'd1;
  localparam logic [1:0] SHIFT_LO  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hex2dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex2dec : registered 4-bit hex to two-digit BCD converter, 1-cycle latency.
// Revision: 1.0
// ---------------------------------------------------------------------------
module hex2dec
  import key_entry_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] din,
  input  logic             din_vld,
  output logic [7:0]       dout,
  output logic             dout_vld
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout     <= 8'h00;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= din_vld;
      if (din_vld) begin
        if (din >= 4'd10) dout <= {4'd1, din - 4'd10};
        else              dout <= {4'd0, din};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_entry_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_entry_ctrl : forwards keys to hex2dec and shifts BCD digits into display.
// Revision: 1.0
// ---------------------------------------------------------------------------
module key_entry_ctrl
  import key_entry_ctrl_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [KEY_W-1:0]             key_code,
  input  logic                         key_vld,
  input  logic                         clr,
  output logic [KEY_W-1:0]             conv_din,
  output logic                         conv_din_vld,
  input  logic [7:0]                   conv_dout,
  input  logic                         conv_dout_vld,
  output logic [4*DIGITS-1:0]          disp_data,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         busy,
  output logic                         upd,
  output logic                         key_drop,
  output logic                         err
);

  localparam int CNT_W = $clog2(DIGITS+1);
  localparam int TMO_W = $clog2(TIMEOUT);

  state_t             r_state;
  nibble_t            r_low;
  logic [TMO_W-1:0]   r_tmo_cnt;

  nibble_t            w_hi;
  nibble_t            w_lo;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_hi = conv_dout[7:4];
  assign w_lo = conv_dout[3:0];
  assign busy = (r_state != IDLE);

  // Saturating digit count after one more shift.
  assign w_cnt_inc = (digit_cnt == CNT_W'(DIGITS)) ? digit_cnt : digit_cnt + 1'b1;

  function automatic logic [4*DIGITS-1:0] shift_in(input logic [4*DIGITS-1:0] buf_in,
                                                   input nibble_t d);
    return {buf_in[4*DIGITS-5:0], d};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_low        <= '0;
      r_tmo_cnt    <= '0;
      conv_din     <= '0;
      conv_din_vld <= 1'b0;
      disp_data    <= '0;
      digit_cnt    <= '0;
      upd          <= 1'b0;
      key_drop     <= 1'b0;
      err          <= 1'b0;
    end else begin
      conv_din_vld <= 1'b0;
      upd          <= 1'b0;
      key_drop     <= 1'b0;
      err          <= 1'b0;
      if (clr) begin
        r_state   <= IDLE;
        r_tmo_cnt <= '0;
        disp_data <= '0;
        digit_cnt <= '0;
      end else begin
        if (key_vld && (r_state != IDLE)) key_drop <= 1'b1;
        case (r_state)
          IDLE: begin
            if (key_vld) begin
              conv_din     <= key_code;
              conv_din_vld <= 1'b1;
              r_tmo_cnt    <= '0;
              r_state      <= WAIT_CONV;
            end
          end
          WAIT_CONV: begin
            // err is flagged one cycle before leaving, so the abort cycle stays busy.
            if (err) begin
              r_state <= IDLE;
            end else if (conv_dout_vld) begin
              digit_cnt <= w_cnt_inc;
              if (w_hi != 4'd0) begin
                disp_data <= shift_in(disp_data, w_hi);
                r_low     <= w_lo;
                r_state   <= SHIFT_LO;
              end else begin
                disp_data <= shift_in(disp_data, w_lo);
                upd       <= 1'b1;
                r_state   <= IDLE;
              end
            end else if (r_tmo_cnt == TMO_W'(TIMEOUT-1)) begin
              err <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
          SHIFT_LO: begin
            disp_data <= shift_in(disp_data, r_low);
            digit_cnt <= w_cnt_inc;
            upd       <= 1'b1;
            r_state   <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_entry_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_key_entry_ctrl : directed self-checking bench with the real hex2dec.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_key_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_vld;
  logic        clr;
  logic [3:0]  conv_din;
  logic        conv_din_vld;
  logic [7:0]  conv_dout;
  logic        conv_dout_vld;
  logic        h_vld;
  logic        hold_off;
  logic [15:0] disp_data;
  logic [2:0]  digit_cnt;
  logic        busy, upd, key_drop, err;

  int checks = 0;
  int failures = 0;
  int n_din_vld = 0, n_upd = 0, n_drop = 0;

  always #5 clk = ~clk;

  assign conv_dout_vld = h_vld & ~hold_off;

  key_entry_ctrl #(.DIGITS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_vld(key_vld), .clr(clr),
    .conv_din(conv_din), .conv_din_vld(conv_din_vld),
    .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld),
    .disp_data(disp_data), .digit_cnt(digit_cnt), .busy(busy),
    .upd(upd), .key_drop(key_drop), .err(err)
  );

  hex2dec u_conv (
    .clk(clk), .rst_n(rst_n), .din(conv_din), .din_vld(conv_din_vld),
    .dout(conv_dout), .dout_vld(h_vld)
  );

  always @(negedge clk) begin
    if (conv_din_vld) n_din_vld++;
    if (upd)          n_upd++;
    if (key_drop)     n_drop++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_vld = 1'b1; key_code = code;
    step();
    key_vld = 1'b0;
    for (int i = 0; i < 12 && busy; i++) step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL press_idle key=%0d busy=%b required 0", code, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; key_vld = 1'b0; key_code = 4'd0; hold_off = 1'b0;
    step(); step();
    rst_n = 1'b1;
    checks++;
    if (disp_data !== 16'h0 || digit_cnt !== 3'd0 || busy !== 1'b0 || upd !== 1'b0 ||
        err !== 1'b0 || key_drop !== 1'b0 || conv_din_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset disp=%h cnt=%0d busy=%b upd=%b err=%b drop=%b dvld=%b required all 0",
               disp_data, digit_cnt, busy, upd, err, key_drop, conv_din_vld);
    end
  endtask

  task automatic test_single();
    key_vld = 1'b1; key_code = 4'd7;
    step();
    key_vld = 1'b0;
    checks++;
    if (conv_din_vld !== 1'b1 || conv_din !== 4'd7 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_c1 dvld=%b din=%0d busy=%b required 1/7/1", conv_din_vld, conv_din, busy);
    end
    step();
    checks++;
    if (busy !== 1'b1 || disp_data !== 16'h0 || conv_din_vld !== 1'b0) begin
      failures++;
      $display("FAIL single_c2 busy=%b disp=%h dvld=%b required 1/0000/0", busy, disp_data, conv_din_vld);
    end
    step();
    checks++;
    if (disp_data !== 16'h0007 || digit_cnt !== 3'd1 || upd !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_c3 disp=%h cnt=%0d upd=%b busy=%b required 0007/1/1/0",
               disp_data, digit_cnt, upd, busy);
    end
  endtask

  task automatic test_back_to_back();
    int u0;
    key_vld = 1'b1; key_code = 4'd12;
    step();
    key_vld = 1'b0;
    checks++;
    if (conv_din !== 4'd12 || conv_din_vld !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept din=%0d dvld=%b required 12/1", conv_din, conv_din_vld);
    end
    step(); step();
    u0 = n_upd;
    checks++;
    if (disp_data !== 16'h0071 || digit_cnt !== 3'd2 || upd !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hi disp=%h cnt=%0d upd=%b busy=%b required 0071/2/0/1",
               disp_data, digit_cnt, upd, busy);
    end
    step();
    checks++;
    if (disp_data !== 16'h0712 || digit_cnt !== 3'd3 || upd !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_lo disp=%h cnt=%0d upd=%b busy=%b required 0712/3/1/0",
               disp_data, digit_cnt, upd, busy);
    end
    step();
    checks++;
    if (n_upd - u0 !== 1) begin
      failures++;
      $display("FAIL b2b_upd_count got=%0d required 1", n_upd - u0);
    end
  endtask

  task automatic test_saturate();
    press(4'd3); press(4'd4); press(4'd5); press(4'd6); press(4'd8);
    checks++;
    if (disp_data !== 16'h4568 || digit_cnt !== 3'd4) begin
      failures++;
      $display("FAIL saturate disp=%h cnt=%0d required 4568/4", disp_data, digit_cnt);
    end
  endtask

  task automatic test_timeout();
    hold_off = 1'b1;
    key_vld = 1'b1; key_code = 4'd5;
    step();
    key_vld = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_c8 err=%b busy=%b required 0/1", err, busy);
    end
    step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_c9 err=%b busy=%b required 1/1", err, busy);
    end
    step();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || disp_data !== 16'h4568 || digit_cnt !== 3'd4) begin
      failures++;
      $display("FAIL timeout_c10 err=%b busy=%b disp=%h cnt=%0d required 0/0/4568/4",
               err, busy, disp_data, digit_cnt);
    end
    hold_off = 1'b0;
    press(4'd2);
    checks++;
    if (disp_data !== 16'h5682) begin
      failures++;
      $display("FAIL timeout_recover disp=%h required 5682", disp_data);
    end
  endtask

  task automatic test_key_drop();
    int d0;
    d0 = n_din_vld;
    key_vld = 1'b1; key_code = 4'd15;
    step();
    key_vld = 1'b0;
    step();
    key_vld = 1'b1; key_code = 4'd3;
    step();
    key_vld = 1'b0;
    checks++;
    if (key_drop !== 1'b1 || disp_data !== 16'h6821 || busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_c3 drop=%b disp=%h busy=%b required 1/6821/1", key_drop, disp_data, busy);
    end
    step();
    checks++;
    if (disp_data !== 16'h8215 || upd !== 1'b1 || key_drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_c4 disp=%h upd=%b drop=%b required 8215/1/0", disp_data, upd, key_drop);
    end
    step(); step();
    checks++;
    if (n_din_vld - d0 !== 1) begin
      failures++;
      $display("FAIL drop_din_vld_count got=%0d required 1", n_din_vld - d0);
    end
  endtask

  task automatic test_clear();
    int u0, k0;
    key_vld = 1'b1; key_code = 4'd9;
    step();
    key_vld = 1'b0;
    step();
    u0 = n_upd; k0 = n_drop;
    checks++;
    if (conv_dout_vld !== 1'b1) begin
      failures++;
      $display("FAIL clr_conv_vld got=%b required 1", conv_dout_vld);
    end
    clr = 1'b1; key_vld = 1'b1; key_code = 4'd4;
    step();
    clr = 1'b0; key_vld = 1'b0;
    checks++;
    if (disp_data !== 16'h0 || digit_cnt !== 3'd0 || busy !== 1'b0 || upd !== 1'b0 ||
        key_drop !== 1'b0) begin
      failures++;
      $display("FAIL clr_c3 disp=%h cnt=%0d busy=%b upd=%b drop=%b required 0/0/0/0/0",
               disp_data, digit_cnt, busy, upd, key_drop);
    end
    step(); step();
    checks++;
    if (n_upd !== u0 || n_drop !== k0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_quiet upd_cnt=%0d drop_cnt=%0d busy=%b required %0d/%0d/0",
               n_upd, n_drop, busy, u0, k0);
    end
    press(4'd4);
    key_vld = 1'b1; key_code = 4'd13;
    step();
    key_vld = 1'b0;
    step(); step();
    checks++;
    if (disp_data !== 16'h0041 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre disp=%h busy=%b required 0041/1", disp_data, busy);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (disp_data !== 16'h0 || digit_cnt !== 3'd0 || busy !== 1'b0 || upd !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid disp=%h cnt=%0d busy=%b upd=%b required 0/0/0/0",
               disp_data, digit_cnt, busy, upd);
    end
    press(4'd6);
    checks++;
    if (disp_data !== 16'h0006 || digit_cnt !== 3'd1) begin
      failures++;
      $display("FAIL rst_recover disp=%h cnt=%0d required 0006/1", disp_data, digit_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_timeout();
    test_key_drop();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Keypad entry controller for the array-key project. It accepts 4-bit key codes from the key scanner and sends each one through the hex-to-decimal converter (`hex2dec`, 1-cycle latency, `{hi,low}` BCD output). It shifts the resulting one or two decimal digits into a DIGITS-wide BCD display buffer that drives the seven-segment display. It owns the converter handshake, sequences two-digit results, and times out a missing converter response.

## Interface
- `DIGITS`, 4: number of BCD digits in the display buffer (≥2).
- `TIMEOUT`, 8: cycles to wait for `conv_dout_vld` before aborting (≥2).

- `clk` input 1: system clock. Single clock domain.
- `rst_n` input 1: reset, synchronous, active-low.
- `key_code` input 4: scanned key value, 0–15.
- `key_vld` input 1: one-cycle strobe qualifying `key_code`.
- `clr` input 1: synchronous clear of buffer and sequencing.
- `conv_din` output 4: key code presented to the converter.
- `conv_din_vld` output 1: one-cycle strobe qualifying `conv_din`.
- `conv_dout` input 8: converter result, `{hi[7:4], low[3:0]}`.
- `conv_dout_vld` input 1: converter result strobe.
- `disp_data` output 4*DIGITS: BCD buffer. Nibble 0 (`[3:0]`) holds the newest digit.
- `digit_cnt` output $clog2(DIGITS+1): number of valid digits, saturating at DIGITS.
- `busy` output 1: high whenever the state is not IDLE.
- `upd` output 1: one-cycle pulse when a key's digits are fully committed.
- `key_drop` output 1: one-cycle pulse when a `key_vld` is rejected.
- `err` output 1: one-cycle pulse on converter timeout.

## Operation
- States:
  - IDLE: waiting for a key.
  - WAIT_CONV: waiting for the converter result.
  - SHIFT_LO: second shift of a two-digit result.
- IDLE with `key_vld`:
  - Register `conv_din<=key_code` and `conv_din_vld<=1` for one cycle.
  - Load the timeout counter with 0.
  - Go to WAIT_CONV.
- WAIT_CONV with `conv_dout_vld`:
  - `hi!=0`: shift `hi` into the buffer, latch `low`, go to SHIFT_LO.
  - `hi==0`: shift `low` in, pulse `upd`, go to IDLE.
- WAIT_CONV without `conv_dout_vld`:
  - Increment the counter.
  - When the counter reaches TIMEOUT-1, pulse `err` and go to IDLE. The buffer is unchanged.
- SHIFT_LO: shift the latched `low`, pulse `upd`, go to IDLE.
- Shift operation:
  - `disp_data <= {disp_data[4*DIGITS-5:0], digit}`. The oldest nibble is discarded when the buffer is full.
  - `digit_cnt` increments, saturating at DIGITS.
- `key_vld` while not IDLE: the key is not forwarded, `key_drop` pulses, and state is unaffected.
- `conv_dout_vld` outside WAIT_CONV: ignored.
- `clr`: the next edge zeroes `disp_data`, `digit_cnt` and the counter, and forces IDLE.
  - `clr` has priority over every other event, including a same-cycle `key_vld` (no `key_drop` pulse) and a same-cycle `conv_dout_vld` (no shift).
  - A result arriving after `clr` is ignored.
- Reset (`rst_n==0` at an edge): all outputs and state go to 0/IDLE. Mid-sequence reset behaves like `clr`.

## Timing
- Outputs are registered. The only combinational output is `busy`, decoded from the state register.
- Single-digit key (value 0–9), with `key_vld` in cycle 0:
  - `conv_din_vld` high in cycle 1.
  - Converter responds in cycle 2.
  - `disp_data` and `digit_cnt` update and `upd` pulses in cycle 3.
  - `busy` high in cycles 1–2.
- Two-digit key (value 10–15):
  - Digit '1' visible in cycle 3.
  - `low` digit and `upd` in cycle 4.
  - `busy` high in cycles 1–3.
- Back-to-back: the earliest next key is accepted in the cycle `busy` is first low, giving one key per 3 cycles (single-digit) or 4 cycles (two-digit).
- Timeout: with no response, `err` pulses in cycle 1+TIMEOUT and `busy` is low from cycle 2+TIMEOUT.

## Structure
- Shared array-key package holds:
  - state enum (IDLE, WAIT_CONV, SHIFT_LO);
  - `KEY_W=4` and `BCD_W=4` constants;
  - a key/BCD nibble typedef.
- No sub-module inside the controller. The converter is instantiated beside it at the array-key top level.
- The bench wires in the real `hex2dec`.

## Test plan
- Reset, then key 7:
  - `conv_din=7` in cycle 1;
  - `disp_data=0x0007`, `digit_cnt=1` and `upd` in cycle 3.
- Key 12 after key 7:
  - cycle 3 gives `0x0071`;
  - cycle 4 gives `0x0712`, `digit_cnt=3`, one `upd`.
- Keys 3, 4, 5, 6, 8 (DIGITS=4) → `disp_data=0x4568`, `digit_cnt=4` (saturated).
- Converter output held off (no `conv_dout_vld`), TIMEOUT=8, key 5:
  - `err` pulse in cycle 9;
  - `disp_data` unchanged;
  - next key accepted normally.
- Key 15, then `key_vld` in cycle 2:
  - `key_drop` pulses in cycle 3;
  - buffer ends `…15`;
  - only one `conv_din_vld`.
- `clr` asserted in the same cycle as `conv_dout_vld` for key 9:
  - `disp_data=0`, `digit_cnt=0`, IDLE;
  - no `upd`;
  - mid-sequence `rst_n=0` gives the same result.
